// File: rtl/wisc_pkg.sv
// wisc_pkg: opcodes, flag-register bit positions and saturation helpers shared by the WISC pipeline.
package wisc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Input is a sign-extended 17-bit sum; bits 16 and 15 disagree only on overflow.
    function automatic logic [15:0] sat16(input logic [16:0] s);
        return (s[16] ^ s[15]) ? (s[16] ? 16'h8000 : 16'h7FFF) : s[15:0];
    endfunction

    function automatic logic [3:0] sat4(input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        s = {x[3], x} + {y[3], y};
        return (s[4] ^ s[3]) ? (s[4] ? 4'h8 : 4'h7) : s[3:0];
    endfunction

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational WISC execute datapath; produces the result, candidate {Z,V,N} flags
// and a per-flag update mask for the opcode.
module ex_alu
    import wisc_pkg::*;
(
    input  opcode_e     op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [7:0]  imm_i,
    input  logic [3:0]  offset_i,
    input  logic [15:0] pc_inc_i,
    output logic [15:0] result_o,
    output logic [2:0]  flags_o,
    output logic [2:0]  flags_en_o
);

    logic [16:0] add_s;
    logic [16:0] sub_s;
    logic [9:0]  red_s;
    logic [31:0] ror_w;
    logic [3:0]  sh;
    logic        ovf;

    assign sh    = imm_i[3:0];
    assign add_s = {a_i[15], a_i} + {b_i[15], b_i};
    assign sub_s = {a_i[15], a_i} - {b_i[15], b_i};
    assign red_s = {{2{a_i[15]}}, a_i[15:8]} + {{2{b_i[15]}}, b_i[15:8]}
                 + {{2{a_i[7]}}, a_i[7:0]} + {{2{b_i[7]}}, b_i[7:0]};
    assign ror_w = {a_i, a_i} >> sh;
    assign ovf   = (op_i == OP_SUB) ? (sub_s[16] ^ sub_s[15]) : (add_s[16] ^ add_s[15]);

    always_comb begin
        result_o   = '0;
        flags_en_o = '0;
        case (op_i)
            OP_ADD: begin
                result_o   = sat16(add_s);
                flags_en_o = 3'b111;
            end
            OP_SUB: begin
                result_o   = sat16(sub_s);
                flags_en_o = 3'b111;
            end
            OP_XOR: begin
                result_o   = a_i ^ b_i;
                flags_en_o = 3'b100;
            end
            OP_SLL: begin
                result_o   = a_i << sh;
                flags_en_o = 3'b100;
            end
            OP_SRA: begin
                result_o   = 16'($signed(a_i) >>> sh);
                flags_en_o = 3'b100;
            end
            OP_ROR: begin
                result_o   = ror_w[15:0];
                flags_en_o = 3'b100;
            end
            OP_RED:    result_o = {{6{red_s[9]}}, red_s};
            OP_PADDSB: result_o = {sat4(a_i[15:12], b_i[15:12]), sat4(a_i[11:8], b_i[11:8]),
                                   sat4(a_i[7:4], b_i[7:4]), sat4(a_i[3:0], b_i[3:0])};
            OP_LW, OP_SW: result_o = (a_i & 16'hFFFE) + {{11{offset_i[3]}}, offset_i, 1'b0};
            OP_LLB:    result_o = (b_i & 16'hFF00) | {8'h00, imm_i};
            OP_LHB:    result_o = (b_i & 16'h00FF) | {imm_i, 8'h00};
            OP_PCS:    result_o = pc_inc_i;
            default:   result_o = '0;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_Z] = (result_o == 16'h0000);
        flags_o[FLAG_V] = ovf;
        flags_o[FLAG_N] = result_o[15];
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: WISC execute stage with operand forwarding, {Z,V,N} flag register and EX/MEM register.
// Define EX_FWD_EN to enable MEM/WB forwarding; otherwise operands come straight from the register file.
module ex_mem_stage
    import wisc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [3:0]         ex_opcode,
    input  logic [DATA_W-1:0]  ex_rs_data,
    input  logic [DATA_W-1:0]  ex_rt_data,
    input  logic [RADDR_W-1:0] ex_rs,
    input  logic [RADDR_W-1:0] ex_rt,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic [7:0]         ex_imm,
    input  logic [3:0]         ex_mem_offset,
    input  logic               ex_reg_write,
    input  logic               ex_mem_write,
    input  logic               ex_mem_to_reg,
    input  logic               ex_pcs,
    input  logic [DATA_W-1:0]  ex_pc_inc,
    input  logic               ex_halt,
    input  logic [RADDR_W-1:0] fw_mem_rd,
    input  logic               fw_mem_we,
    input  logic [DATA_W-1:0]  fw_mem_data,
    input  logic [RADDR_W-1:0] fw_wb_rd,
    input  logic               fw_wb_we,
    input  logic [DATA_W-1:0]  fw_wb_data,
    output logic [DATA_W-1:0]  mem_alu_out,
    output logic [DATA_W-1:0]  mem_st_data,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_reg_write,
    output logic               mem_mem_write,
    output logic               mem_mem_to_reg,
    output logic               mem_halt,
    output logic [2:0]         flags
);

    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  alu_res;
    logic [2:0]         alu_flags;
    logic [2:0]         alu_flags_en;
    logic [2:0]         flags_upd;
    logic [DATA_W-1:0]  alu_out_q;
    logic [DATA_W-1:0]  st_data_q;
    logic [RADDR_W-1:0] rd_q;
    logic               reg_write_q;
    logic               mem_write_q;
    logic               mem_to_reg_q;
    logic               halt_q;
    logic [2:0]         flags_q;
    logic [2:0]         flags_d;

`ifdef EX_FWD_EN
    // A zero source can never match a writeback, so the rd!=0 rule falls out of the R0 case.
    assign op_a = (ex_rs == '0) ? '0 :
                  (fw_mem_we && fw_mem_rd == ex_rs) ? fw_mem_data :
                  (fw_wb_we && fw_wb_rd == ex_rs) ? fw_wb_data : ex_rs_data;
    assign op_b = (ex_rt == '0) ? '0 :
                  (fw_mem_we && fw_mem_rd == ex_rt) ? fw_mem_data :
                  (fw_wb_we && fw_wb_rd == ex_rt) ? fw_wb_data : ex_rt_data;
`else
    logic unused_fw;
    assign unused_fw = ^{ex_rs, ex_rt, fw_mem_rd, fw_mem_we, fw_mem_data,
                         fw_wb_rd, fw_wb_we, fw_wb_data};
    assign op_a      = ex_rs_data;
    assign op_b      = ex_rt_data;
`endif

    ex_alu u_alu (
        .op_i       (ex_pcs ? OP_PCS : opcode_e'(ex_opcode)),
        .a_i        (op_a),
        .b_i        (op_b),
        .imm_i      (ex_imm),
        .offset_i   (ex_mem_offset),
        .pc_inc_i   (ex_pc_inc),
        .result_o   (alu_res),
        .flags_o    (alu_flags),
        .flags_en_o (alu_flags_en)
    );

    // Every flag-setting opcode writes Rd, so an ID/EX bubble (reg_write=0) never touches flags.
    assign flags_upd = ex_reg_write ? alu_flags_en : 3'b000;
    assign flags_d   = (flags_upd & alu_flags) | (~flags_upd & flags_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q    <= '0;
            st_data_q    <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halt_q       <= 1'b0;
            flags_q      <= '0;
        end else if (flush) begin
            alu_out_q    <= '0;
            st_data_q    <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            halt_q       <= 1'b0;
        end else if (!stall) begin
            alu_out_q    <= alu_res;
            st_data_q    <= op_b;
            rd_q         <= ex_rd;
            reg_write_q  <= ex_reg_write;
            mem_write_q  <= ex_mem_write;
            mem_to_reg_q <= ex_mem_to_reg;
            halt_q       <= ex_halt;
            flags_q      <= flags_d;
        end
    end

    assign mem_alu_out    = alu_out_q;
    assign mem_st_data    = st_data_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_mem_to_reg = mem_to_reg_q;
    assign mem_halt       = halt_q;
    assign flags          = flags_q;

endmodule
